// File: rtl/add_block_accumulator_if.sv
// Valid/ready bundle between the adder result stream and the block accumulator.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface add_block_accumulator_if #(
    parameter int IN_W  = 33,
    parameter int ACC_W = 40,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_count, out_sat
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_sat
    );
endinterface

// File: rtl/add_block_accumulator.sv
// Sums BLOCK_LEN adder results (or fewer on flush) and holds the block total until taken.
// Optional clamping of the block sum is enabled by defining ADD_BLOCK_ACCUM_SATURATE_EN.
module add_block_accumulator #(
    parameter int IN_W      = 33,
    parameter int ACC_W     = 40,
    parameter int BLOCK_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    add_block_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(BLOCK_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, out_data_q, acc_add_s;
    logic [CNT_W-1:0] cnt_q, cnt_d, out_count_q;
    logic             in_ready_q, out_valid_q;
    logic             accept_s, close_s;

`ifdef ADD_BLOCK_ACCUM_SATURATE_EN
    localparam int SUM_W = ACC_W + 1;
    logic [SUM_W-1:0] sum_s;
    logic             ovf_s;
    logic             sat_q, sat_d, out_sat_q;

    // Wide add; the carry out of ACC_W bits clamps the accumulator to all-ones.
    always_comb begin
        sum_s = {1'b0, acc_q} + SUM_W'(bus.in_data);
        ovf_s = sum_s[ACC_W];
        if (ovf_s) begin
            acc_add_s = {ACC_W{1'b1}};
        end else begin
            acc_add_s = sum_s[ACC_W-1:0];
        end
    end
`else
    // Modulo-2^ACC_W add of the zero-extended sample.
    always_comb begin
        acc_add_s = acc_q + ACC_W'(bus.in_data);
    end
`endif

    assign accept_s = in_ready_q & bus.in_valid;

    // Next-state, accumulator update and block-close decision.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        close_s = 1'b0;
`ifdef ADD_BLOCK_ACCUM_SATURATE_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            ST_ACCUM: begin
                if (accept_s) begin
                    acc_d = acc_add_s;
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef ADD_BLOCK_ACCUM_SATURATE_EN
                    sat_d = sat_q | ovf_s;
`endif
                end else begin
                    acc_d = acc_q;
                    cnt_d = cnt_q;
                end
                // An empty block never closes; a flush with an accept includes that sample.
                if ((accept_s && (cnt_q == LAST_CNT)) ||
                    (bus.flush && (accept_s || (cnt_q != {CNT_W{1'b0}})))) begin
                    close_s = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_ACCUM;
                    acc_d   = {ACC_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
`ifdef ADD_BLOCK_ACCUM_SATURATE_EN
                    sat_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State, accumulator and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {ACC_W{1'b0}};
            out_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == ST_ACCUM);
            out_valid_q <= (state_d == ST_HOLD);
            if (close_s) begin
                out_data_q  <= acc_d;
                out_count_q <= cnt_d;
            end else begin
                out_data_q  <= out_data_q;
                out_count_q <= out_count_q;
            end
        end
    end

`ifdef ADD_BLOCK_ACCUM_SATURATE_EN
    // Sticky per-block saturation flag and its registered output copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q     <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
            if (close_s) begin
                out_sat_q <= sat_d;
            end else begin
                out_sat_q <= out_sat_q;
            end
        end
    end

    assign bus.out_sat = out_sat_q;
`else
    assign bus.out_sat = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_add_block_accumulator.sv
// Bench for add_block_accumulator (BLOCK_LEN=4, ACC_W=34): directed table, corner
// sequences and a randomized run against a block-sum reference model.
module tb_add_block_accumulator;
    localparam int IN_W  = 33;
    localparam int ACC_W = 34;
    localparam int BL    = 4;
    localparam int CNT_W = 3;

`ifdef ADD_BLOCK_ACCUM_SATURATE_EN
    localparam logic [33:0] OVF_DATA = 34'h3_FFFF_FFFF;
    localparam logic        OVF_SAT  = 1'b1;
`else
    localparam logic [33:0] OVF_DATA = 34'h3_FFFF_FFFC;
    localparam logic        OVF_SAT  = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    add_block_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    add_block_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .BLOCK_LEN(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [32:0] d;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [33:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_sat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [32:0] d, input logic fl, input logic ordy);
        bus.in_valid  = vld;
        bus.in_data   = d;
        bus.flush     = fl;
        bus.out_ready = ordy;
    endtask

    task automatic addv(input logic vld, input logic [32:0] d, input logic fl,
                        input logic e_ir, input logic e_ov, input logic [33:0] e_data,
                        input logic [2:0] e_cnt, input logic e_sat);
        vec_t v;
        v.vld = vld; v.d = d; v.fl = fl; v.ordy = 1'b1;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_data = e_data; v.e_cnt = e_cnt; v.e_sat = e_sat;
        tbl.push_back(v);
    endtask

    task automatic chk_out(input string tag, input logic [33:0] data, input logic [2:0] cnt,
                           input logic sat);
        chk({tag, "_data"}, 64'(bus.out_data), 64'(data));
        chk({tag, "_count"}, 64'(bus.out_count), 64'(cnt));
        chk({tag, "_sat"}, 64'(bus.out_sat), 64'(sat));
    endtask

    // Reference model state: samples of the open block and the pending block result.
    logic [32:0] blk[$];
    logic        pend;
    logic [33:0] pend_data;
    logic [2:0]  pend_cnt;
    logic        pend_sat;

    task automatic model_close();
        logic [63:0] total;
        total = 64'd0;
        foreach (blk[i]) total += 64'(blk[i]);
        pend_cnt = 3'(blk.size());
`ifdef ADD_BLOCK_ACCUM_SATURATE_EN
        pend_sat  = (total > 64'h3_FFFF_FFFF);
        pend_data = pend_sat ? 34'h3_FFFF_FFFF : total[33:0];
`else
        pend_sat  = 1'b0;
        pend_data = total[33:0];
`endif
        pend = 1'b1;
        blk.delete();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 33'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk_out("rst", 34'd0, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);

        // Full block, flush cases and overflow block.
        addv(1'b1, 33'h0_0000_0001, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        addv(1'b1, 33'h0_0000_0002, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        addv(1'b1, 33'h1_0000_0000, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        addv(1'b1, 33'h1_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 34'h3_0000_0002, 3'd4, 1'b0);
        addv(1'b0, 33'd0, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        addv(1'b1, 33'd5, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        addv(1'b1, 33'd5, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        addv(1'b1, 33'd5, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        addv(1'b0, 33'd0, 1'b1, 1'b0, 1'b1, 34'd15, 3'd3, 1'b0);
        addv(1'b0, 33'd0, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        addv(1'b0, 33'd0, 1'b1, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        addv(1'b1, 33'd5, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        addv(1'b1, 33'd7, 1'b1, 1'b0, 1'b1, 34'd12, 3'd2, 1'b0);
        addv(1'b0, 33'd0, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        for (int k = 0; k < 3; k++)
            addv(1'b1, 33'h1_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);
        addv(1'b1, 33'h1_FFFF_FFFF, 1'b0, 1'b0, 1'b1, OVF_DATA, 3'd4, OVF_SAT);
        addv(1'b0, 33'd0, 1'b0, 1'b1, 1'b0, 34'd0, 3'd0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].vld, tbl[i].d, tbl[i].fl, tbl[i].ordy);
            tick();
            chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov)
                chk_out($sformatf("tbl%0d", i), tbl[i].e_data, tbl[i].e_cnt, tbl[i].e_sat);
        end

        // Backpressure: result must hold and no sample may slip in while HOLD persists.
        drive(1'b1, 33'h0_0000_0001, 1'b0, 1'b0); tick();
        drive(1'b1, 33'h0_0000_0002, 1'b0, 1'b0); tick();
        drive(1'b1, 33'h1_0000_0000, 1'b0, 1'b0); tick();
        drive(1'b1, 33'h1_FFFF_FFFF, 1'b0, 1'b0); tick();
        chk_out("bp_first", 34'h3_0000_0002, 3'd4, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 33'd5, 1'b1, 1'b0);
            tick();
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk_out("bp_hold", 34'h3_0000_0002, 3'd4, 1'b0);
        end
        drive(1'b0, 33'd0, 1'b0, 1'b1); tick();
        chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 33'd9, 1'b1, 1'b0); tick();
        chk("bp_next_valid", 64'(bus.out_valid), 64'd1);
        chk_out("bp_next", 34'd9, 3'd1, 1'b0);
        drive(1'b0, 33'd0, 1'b0, 1'b1); tick();
        chk("bp_next_taken", 64'(bus.out_valid), 64'd0);

        // Reset mid-block discards the partial sum and clears the held result.
        drive(1'b1, 33'd1, 1'b0, 1'b1); tick(); tick();
        rst_n = 1'b0;
        drive(1'b0, 33'd0, 1'b0, 1'b1); tick();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        chk_out("mid_rst", 34'd0, 3'd0, 1'b0);
        rst_n = 1'b1; tick();
        chk("mid_rst_release", 64'(bus.in_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 33'd1, 1'b0, 1'b1);
            tick();
        end
        chk("mid_rst_blk_valid", 64'(bus.out_valid), 64'd1);
        chk_out("mid_rst_blk", 34'd4, 3'd4, 1'b0);
        drive(1'b0, 33'd0, 1'b0, 1'b1); tick();

        // Randomized traffic against the block-sum model, from a fresh reset.
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
        blk.delete();
        pend = 1'b0; pend_data = 34'd0; pend_cnt = 3'd0; pend_sat = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            logic        iv, fl, ordy;
            logic [32:0] d;
            iv   = ($urandom_range(9, 0) < 7);
            fl   = ($urandom_range(9, 0) == 0);
            ordy = ($urandom_range(1, 0) == 1);
            d    = {1'($urandom_range(1, 0)), 32'($urandom())};
            drive(iv, d, fl, ordy);
            if (!pend) begin
                if (iv) blk.push_back(d);
                if ((blk.size() == BL) || (fl && (blk.size() > 0))) model_close();
            end else if (ordy) begin
                pend = 1'b0;
            end
            tick();
            chk("rnd_in_ready", 64'(bus.in_ready), 64'(!pend));
            chk("rnd_out_valid", 64'(bus.out_valid), 64'(pend));
            if (pend) chk_out("rnd", pend_data, pend_cnt, pend_sat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
